// File: rtl/deal_arbiter.sv
// Card-deal arbiter: round-robin player/dealer grants, LFSR-driven card draw.
// Define DEAL_UNIQUE_CARDS_EN for a no-replacement deck; otherwise cards are drawn with replacement.
`timescale 1ns/1ps
module deal_arbiter #(
   parameter int DECK_SIZE = 52
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_player_req,
   input  logic       i_dealer_req,
   input  logic       i_new_round,
   output logic       o_player_ack,
   output logic       o_dealer_ack,
   output logic [3:0] o_card_rank,
   output logic [1:0] o_card_suit,
   output logic       o_busy,
   output logic [5:0] o_cards_left,
   output logic       o_deck_empty
);

   // state     | meaning
   // S_IDLE    | waiting for a request
   // S_DRAW    | sampling LFSR until an acceptable card appears
   // S_DELIVER | ack pulse for the granted requester
   // S_EMPTY   | deck exhausted, waiting for a new round
   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DELIVER, S_EMPTY} state_t;

   localparam logic [5:0] DeckCount = 6'(DECK_SIZE);

   state_t      state;
   logic [15:0] lfsr;
   logic [5:0]  idx;
   logic [5:0]  rem;
   logic [1:0]  candSuit;
   logic [3:0]  candRank;
   logic        inRange;
   logic        candValid;
   logic        deckOut;
   logic        drawHit;
   logic        grantDealer;
   logic        lastDealer;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) lfsr <= 16'hACE1;
      else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign idx     = lfsr[5:0];
   assign inRange = idx < DeckCount;

   // Suit/rank split by descending compare-subtract instead of a divider.
   always_comb begin
      candSuit = 2'd0;
      rem      = idx;
      if (idx >= 6'd39) begin
         candSuit = 2'd3;
         rem      = idx - 6'd39;
      end else if (idx >= 6'd26) begin
         candSuit = 2'd2;
         rem      = idx - 6'd26;
      end else if (idx >= 6'd13) begin
         candSuit = 2'd1;
         rem      = idx - 6'd13;
      end
      candRank = 4'(rem) + 4'd1;
   end

   assign drawHit = (state == S_DRAW) && candValid;

`ifdef DEAL_UNIQUE_CARDS_EN
   logic [DECK_SIZE-1:0] used;
   logic [5:0]           cardsLeft;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         used      <= '0;
         cardsLeft <= DeckCount;
      end else if (i_new_round) begin
         used      <= '0;
         cardsLeft <= DeckCount;
      end else begin
         if (drawHit) used[idx] <= 1'b1;
         if (state == S_DELIVER) cardsLeft <= cardsLeft - 6'd1;
      end
   end

   assign candValid    = inRange && !used[idx];
   assign deckOut      = (cardsLeft == 6'd0);
   assign o_cards_left = cardsLeft;
   assign o_deck_empty = (state == S_EMPTY);
`else
   assign candValid    = inRange;
   assign deckOut      = 1'b0;
   assign o_cards_left = DeckCount;
   assign o_deck_empty = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state        <= S_IDLE;
         o_player_ack <= 1'b0;
         o_dealer_ack <= 1'b0;
         o_card_rank  <= 4'd0;
         o_card_suit  <= 2'd0;
         grantDealer  <= 1'b0;
         lastDealer   <= 1'b0;
      end else begin
         o_player_ack <= 1'b0;
         o_dealer_ack <= 1'b0;
         if (i_new_round) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (i_player_req || i_dealer_req) begin
                     if (deckOut) begin
                        state <= S_EMPTY;
                     end else begin
                        // Dealer wins a tie only when the player was granted last.
                        grantDealer <= i_dealer_req && (!i_player_req || !lastDealer);
                        lastDealer  <= i_dealer_req && (!i_player_req || !lastDealer);
                        state       <= S_DRAW;
                     end
                  end
               end
               S_DRAW: begin
                  if (drawHit) begin
                     o_card_rank  <= candRank;
                     o_card_suit  <= candSuit;
                     o_player_ack <= !grantDealer;
                     o_dealer_ack <= grantDealer;
                     state        <= S_DELIVER;
                  end
               end
               S_DELIVER: state <= S_IDLE;
               S_EMPTY:   state <= S_EMPTY;
               default:   state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_deal_arbiter.sv
// Directed bench for deal_arbiter; expectations follow DEAL_UNIQUE_CARDS_EN when defined.
`timescale 1ns/1ps
module tb_deal_arbiter;

   logic       clk = 1'b0;
   logic       rst, preq, dreq, nr;
   logic       pAck, dAck, busy, empty;
   logic [3:0] rank;
   logic [1:0] suit;
   logic [5:0] left;

   int vectors = 0;
   int miscompares = 0;
   int bothAck = 0;

   always #5 clk = ~clk;

   deal_arbiter #(.DECK_SIZE(52)) dut (
      .i_clk(clk), .i_reset(rst), .i_player_req(preq), .i_dealer_req(dreq),
      .i_new_round(nr), .o_player_ack(pAck), .o_dealer_ack(dAck),
      .o_card_rank(rank), .o_card_suit(suit), .o_busy(busy),
      .o_cards_left(left), .o_deck_empty(empty)
   );

   always @(negedge clk) if (pAck && dAck) bothAck++;

`ifdef DEAL_UNIQUE_CARDS_EN
   localparam bit Unique = 1'b1;
`else
   localparam bit Unique = 1'b0;
`endif

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drawOne(input bit forDealer, output bit got, output int cyc);
      got = 1'b0;
      cyc = 0;
      if (forDealer) dreq = 1'b1; else preq = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         cyc++;
         if (forDealer ? dAck : pAck) begin
            got = 1'b1;
            break;
         end
      end
      preq = 1'b0;
      dreq = 1'b0;
   endtask

   task automatic pulseNewRound();
      @(negedge clk);
      nr = 1'b1;
      @(negedge clk);
      nr = 1'b0;
   endtask

   initial begin
      bit      got, firstDealer, gotP, gotD, ackSeen;
      int      cyc, acks, dups, bad, idx;
      bit [51:0] seen;

      rst = 1'b1; preq = 1'b0; dreq = 1'b0; nr = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pack", pAck, 0);
      check("rst_dack", dAck, 0);
      check("rst_rank", rank, 0);
      check("rst_busy", busy, 0);
      check("rst_left", left, 52);
      check("rst_empty", empty, 0);
      rst = 1'b0;
      @(negedge clk);

      // single player request
      drawOne(1'b0, got, cyc);
      check("p_ack", got, 1);
      check("p_lat_ge2", int'(cyc >= 2), 1);
      check("p_dack_quiet", dAck, 0);
      check("p_rank_range", int'(rank >= 1 && rank <= 13), 1);
      check("p_suit_range", int'(suit <= 3), 1);
      @(negedge clk);
      check("p_left", left, Unique ? 51 : 52);
      check("p_idle", busy, 0);

      // simultaneous requests after a fresh reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      preq = 1'b1; dreq = 1'b1;
      gotP = 1'b0; gotD = 1'b0; firstDealer = 1'b0;
      for (int i = 0; i < 800 && !(gotP && gotD); i++) begin
         @(negedge clk);
         if (dAck && !gotD) begin
            gotD = 1'b1;
            if (!gotP) firstDealer = 1'b1;
            dreq = 1'b0;
         end
         if (pAck && !gotP) begin
            gotP = 1'b1;
            preq = 1'b0;
         end
      end
      preq = 1'b0; dreq = 1'b0;
      check("rr_dealer_first", firstDealer, 1);
      check("rr_player_acked", gotP, 1);
      @(negedge clk);
      check("rr_left", left, Unique ? 50 : 52);

      // full deck (unique) or 60 draws with replacement
      pulseNewRound();
      check("nr_left", left, 52);
      acks = 0; dups = 0; bad = 0; seen = '0;
      for (int i = 0; i < (Unique ? 52 : 60); i++) begin
         drawOne(i[0], got, cyc);
         if (got) acks++;
         if (!(rank >= 1 && rank <= 13)) bad++;
         else begin
            idx = int'(suit) * 13 + int'(rank) - 1;
            if (seen[idx]) dups++;
            seen[idx] = 1'b1;
         end
         @(negedge clk);
      end
      check("deck_acks", acks, Unique ? 52 : 60);
      check("deck_range", bad, 0);
      if (Unique) check("deck_dups", dups, 0);
      check("deck_left", left, Unique ? 0 : 52);
      check("deck_empty_flag", empty, 0);

      // one more request: empties the unique deck, or is simply served
      preq = 1'b1;
      ackSeen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (pAck) ackSeen = 1'b1;
         if (i >= 6 && (ackSeen || !Unique)) break;
      end
      preq = 1'b0;
      check("extra_ack", ackSeen, Unique ? 0 : 1);
      check("extra_empty", empty, Unique ? 1 : 0);
      pulseNewRound();
      check("renew_left", left, 52);
      check("renew_empty", empty, 0);
      drawOne(1'b1, got, cyc);
      check("renew_ack", got, 1);
      @(negedge clk);
      check("renew_left_after", left, Unique ? 51 : 52);

      // new round while drawing
      @(negedge clk);
      preq = 1'b1;
      @(negedge clk);
      check("nrd_in_draw", busy, 1);
      nr = 1'b1; preq = 1'b0;
      @(negedge clk);
      nr = 1'b0;
      check("nrd_idle", busy, 0);
      check("nrd_left", left, 52);
      ackSeen = pAck | dAck;
      repeat (4) begin
         @(negedge clk);
         ackSeen |= pAck | dAck;
      end
      check("nrd_no_ack", ackSeen, 0);

      // asynchronous reset mid-draw
      drawOne(1'b0, got, cyc);
      @(negedge clk);
      @(negedge clk);
      preq = 1'b1;
      @(negedge clk);
      check("ard_in_draw", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("ard_pack", pAck, 0);
      check("ard_dack", dAck, 0);
      check("ard_rank", rank, 0);
      check("ard_suit", suit, 0);
      check("ard_busy", busy, 0);
      check("ard_left", left, 52);
      check("ard_empty", empty, 0);
      preq = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      ackSeen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         ackSeen |= pAck | dAck;
      end
      check("ard_no_ack", ackSeen, 0);

      check("never_both_acks", bothAck, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/deal_arbiter.md
DEAL_ARBITER -- requirements
Module: deal_arbiter

Interface
REQ-001 SHALL have parameter DECK_SIZE, default 52, the number of distinct cards per round (fixed at 52).
REQ-002 SHALL have i_clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have i_reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have i_player_req  input  1  player hand requests one card; level, held until ack.
REQ-005 SHALL have i_dealer_req  input  1  dealer hand requests one card; level, held until ack.
REQ-006 SHALL have i_new_round  input  1  synchronous one-cycle pulse that reshuffles the deck.
REQ-007 SHALL have o_player_ack  output  1  one-cycle pulse; o_card_* valid for the player.
REQ-008 SHALL have o_dealer_ack  output  1  one-cycle pulse; o_card_* valid for the dealer.
REQ-009 SHALL have o_card_rank  output  4  rank 1..13 (1 = ace, 11..13 = J/Q/K).
REQ-010 SHALL have o_card_suit  output  2  suit 0..3.
REQ-011 SHALL have o_busy  output  1  high in any state other than S_IDLE.
REQ-012 SHALL have o_cards_left  output  6  undealt cards, 0..52.
REQ-013 SHALL have o_deck_empty  output  1  high while in S_EMPTY.

Function
REQ-014 SHALL use a 16-bit Fibonacci LFSR with taps 16,14,13,11, seed 16'hACE1, advancing every cycle in every state.
REQ-015 SHALL take the candidate index idx = lfsr[5:0] and reject it when idx >= 52.
REQ-016 SHALL map an accepted idx to suit = idx/13 and rank = (idx mod 13)+1, using compare/subtract and no divider.
REQ-017 SHALL implement the FSM states S_IDLE, S_DRAW, S_DELIVER and S_EMPTY.
REQ-018 In S_IDLE, with any request asserted and o_cards_left > 0, SHALL latch the grant and go to S_DRAW; with o_cards_left == 0, SHALL go to S_EMPTY.
REQ-019 SHALL arbitrate round-robin when both requests are asserted: the requester not granted last wins; after reset, last-grant = player, so the dealer wins first.
REQ-020 SHALL grant a single requester immediately regardless of last-grant.
REQ-021 In S_DRAW, each cycle, if the candidate is valid and unused SHALL mark it used, register rank/suit and go to S_DELIVER; otherwise SHALL stay in S_DRAW.
REQ-022 In S_DELIVER SHALL assert exactly one ack (the granted requester's) for one cycle, decrement o_cards_left and return to S_IDLE.
REQ-023 Minimum latency SHALL be 2 cycles from S_IDLE sampling a request to the ack cycle.
REQ-024 SHALL never assert both acks in the same cycle.
REQ-025 SHALL hold o_card_rank/o_card_suit at their last delivered value between acks.
REQ-026 If the granted request drops during S_DRAW, SHALL still consume the card and pulse the ack.
REQ-027 A request still high in S_IDLE after its ack SHALL be treated as a new request.
REQ-028 S_EMPTY SHALL issue no acks and SHALL exit only on i_new_round.
REQ-029 i_new_round in any state SHALL clear the used bitmap, set o_cards_left = 52, abort any pending draw with no ack, and go to S_IDLE.
REQ-030 i_new_round SHALL take priority over requests sampled in the same cycle.

Reset
REQ-031 i_reset SHALL immediately force: state S_IDLE, both acks 0, rank 0, suit 0, o_busy 0, o_cards_left 52, o_deck_empty 0, bitmap cleared, LFSR 16'hACE1, last-grant = player.
REQ-032 Reset mid-draw SHALL discard the draw with no ack.

Configuration
REQ-033 With DEAL_UNIQUE_CARDS_EN defined, SHALL implement the 52-bit used bitmap, duplicate rejection, o_cards_left counting and S_EMPTY.
REQ-034 With DEAL_UNIQUE_CARDS_EN undefined, SHALL draw with replacement: only the idx >= 52 rejection applies, o_cards_left is held at 52, o_deck_empty is tied 0 and S_EMPTY is unreachable.

Verification
REQ-035 Reset, then hold i_player_req -> o_player_ack within 2+ cycles; rank in 1..13, suit in 0..3; o_cards_left 51.
REQ-036 Assert both requests in the same cycle after reset -> dealer acked first, then player; never a simultaneous ack; o_cards_left 50.
REQ-037 52 sequential draws -> 52 distinct (rank, suit) pairs and o_cards_left 0; 53rd request -> o_deck_empty 1 with no ack; i_new_round -> o_cards_left 52 and acks resume.
REQ-038 Pulse i_new_round while in S_DRAW -> no ack, o_cards_left 52, S_IDLE the next cycle.
REQ-039 Assert i_reset asynchronously mid-S_DRAW -> all outputs at the REQ-031 values before the next clock edge; no ack.
REQ-040 With DEAL_UNIQUE_CARDS_EN undefined, 60 draws -> all 60 acked, o_deck_empty 0, o_cards_left 52.
